mole_game_ctrl: RTL and testbench
=================================

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Parameters
REQ-001 The block SHALL have parameter TICK_DIV, default 25_000_000, giving the number of clk cycles per game tick.
REQ-002 The block SHALL have parameter GAME_TICKS, default 60, giving the game length in ticks (range 1..127).
REQ-003 The block SHALL have parameter MOLE_LIFE, default 2, giving the ticks a mole stays up (range 1..15).
REQ-004 The block SHALL have parameter GAP_TICKS, default 1, giving the empty ticks between moles (range 1..15).
REQ-005 The block SHALL have parameter LFSR_SEED, default 16'hACE1, a nonzero 16-bit LFSR reset value.

Interface
REQ-006 clk  in  1  system clock; all state updates on posedge clk.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle start/restart pulse.
REQ-009 hit_pos  in  4  one-cycle key position: 0..8 is a hole, 15 means none, 9..14 are ignored.
REQ-010 mole_mask  out  9  one-hot mole currently up, or all zero.
REQ-011 score  out  8  hit count, saturating.
REQ-012 miss_cnt  out  8  miss count, saturating.
REQ-013 time_left  out  7  remaining game ticks.
REQ-014 game_over  out  1  high while in OVER.
REQ-015 busy  out  1  high in SPAWN, UP or GAP.

Function
REQ-016 The FSM SHALL have states IDLE, SPAWN, UP, GAP and OVER, all outputs SHALL be registered, and all behaviour SHALL be synchronous to clk.
REQ-017 The tick counter SHALL count 0..TICK_DIV-1 only while busy, SHALL assert tick for one cycle at wrap, and SHALL clear to 0 whenever not busy.
REQ-018 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, including in IDLE.
REQ-019 IDLE/OVER + start SHALL lead to SPAWN, with score=0, miss_cnt=0, time_left=GAME_TICKS, prev_pos=15, and the tick counter cleared.
REQ-020 start SHALL be ignored in SPAWN, UP and GAP.
REQ-021 SPAWN (1 cycle) SHALL take p=lfsr[3:0] if <9, else p=lfsr[3:0]-9; if p==prev_pos, p SHALL be (p+1) mod 9.
REQ-022 SPAWN SHALL then set mole_pos=prev_pos=p, life=MOLE_LIFE and go to UP, with mole_mask=1<<p visible from the cycle UP is entered.
REQ-023 A hit in UP (hit_pos==mole_pos at cycle N) SHALL give score+1 (saturating at 255), mole_mask=0, gap=GAP_TICKS and GAP state at N+1.
REQ-024 A wrong hit in UP (hit_pos 0..8 and !=mole_pos) SHALL give miss_cnt+1 (saturating at 255); the mole SHALL stay up.
REQ-025 In UP, each tick SHALL decrement life; when life would reach 0 the block SHALL give miss_cnt+1, mole_mask=0 and go to GAP with gap=GAP_TICKS.
REQ-026 If a correct hit and life expiry occur in the same cycle, the hit SHALL win: score+1, with no miss counted.
REQ-027 In GAP, hits SHALL be ignored; each tick SHALL decrement gap, and at 0 the block SHALL go to SPAWN.
REQ-028 Each tick while busy SHALL decrement time_left; on the tick where time_left goes 1->0, the block SHALL go to OVER with mole_mask=0.
REQ-029 A correct hit in the same cycle as the final tick SHALL be counted before entering OVER.
REQ-030 Timer expiry SHALL take priority over life/gap transitions; no miss SHALL be counted for a mole cut off by game end.
REQ-031 OVER SHALL hold score, miss_cnt and time_left=0, with game_over=1, until start.
REQ-032 hit_pos values 15 and 9..14 SHALL never change state or counters.

Reset
REQ-033 rst SHALL force IDLE, mole_mask=0, score=0, miss_cnt=0, time_left=0, game_over=0, busy=0, tick counter=0, prev_pos=15 and lfsr=LFSR_SEED, taking priority over start and hit_pos.
REQ-034 rst asserted mid-game SHALL abort in the same cycle; after rst, start SHALL be required to play again.

Verification
REQ-035 The bench SHALL use TICK_DIV=4, GAME_TICKS=10, MOLE_LIFE=2 and GAP_TICKS=1, and SHALL cover these scenarios:
REQ-036 Scenario 1: rst then start at cycle N -> busy=1 and time_left=10 at N+1; one-hot mole_mask at N+2.
REQ-037 Scenario 2: hit_pos=mole index while in UP -> score=1 and mole_mask=0 next cycle; GAP for 1 tick, then a new mole at a different position.
REQ-038 Scenario 3: wrong hit_pos (0..8), then hit_pos=12, then no hits -> miss_cnt=1 after the wrong hit; no change for hit_pos=12; miss_cnt=2 after 2 ticks as the mole expires.
REQ-039 Scenario 4: correct hit coincident with the life-expiry tick -> score+1, miss_cnt unchanged.
REQ-040 Scenario 5: run 40 cycles -> time_left reaches 0, game_over=1, mole_mask=0; start -> score=0, miss_cnt=0, time_left=10.
REQ-041 Scenario 6: rst mid-UP, then start pulse during busy -> all outputs 0 and IDLE after rst; start during busy has no effect on time_left.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole game FSM with tick timer, LFSR mole placement and hit/miss scoring.
module mole_game_ctrl #(
    parameter int          TICK_DIV   = 25_000_000,
    parameter int          GAME_TICKS = 60,
    parameter int          MOLE_LIFE  = 2,
    parameter int          GAP_TICKS  = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] hit_pos,
    output logic [8:0] mole_mask,
    output logic [7:0] score,
    output logic [7:0] miss_cnt,
    output logic [6:0] time_left,
    output logic       game_over,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    state_t          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [3:0]      prev_q, pos_q, life_q, gap_q, raw, p_spawn;
    logic [8:0]      mask_q;
    logic [7:0]      score_q, miss_q;
    logic [6:0]      time_q;
    logic            over_q, busy_q;
    logic            tick, last, hit, wrong, expire;
    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tick    = busy_q && cnt_q == CNT_MAX;
    assign cnt_d   = busy_q && !tick ? cnt_q + 1'b1 : '0;
    assign last    = tick && time_q == 7'd1;
    assign hit     = state_q == UP && hit_pos == pos_q;
    assign wrong   = state_q == UP && hit_pos < 4'd9 && hit_pos != pos_q;
    // A mole cut off by game end or hit on its final tick is not a miss.
    assign expire  = state_q == UP && tick && life_q == 4'd1 && !hit && !last;
    assign raw     = lfsr_q[3:0] < 4'd9 ? lfsr_q[3:0] : lfsr_q[3:0] - 4'd9;
    assign p_spawn = raw != prev_q ? raw : raw == 4'd8 ? 4'd0 : raw + 4'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            prev_q  <= 4'd15;
            pos_q   <= 4'd0;
            life_q  <= 4'd0;
            gap_q   <= 4'd0;
            mask_q  <= '0;
            score_q <= '0;
            miss_q  <= '0;
            time_q  <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            if (tick) time_q <= time_q - 7'd1;
            if (hit) score_q <= sat_add(score_q, 2'd1);
            miss_q <= sat_add(miss_q, {1'b0, wrong} + {1'b0, expire});
            if (last) begin
                state_q <= OVER;
                mask_q  <= '0;
                busy_q  <= 1'b0;
                over_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, OVER: if (start) begin
                        state_q <= SPAWN;
                        busy_q  <= 1'b1;
                        over_q  <= 1'b0;
                        score_q <= '0;
                        miss_q  <= '0;
                        time_q  <= 7'(GAME_TICKS);
                        prev_q  <= 4'd15;
                    end
                    SPAWN: begin
                        pos_q   <= p_spawn;
                        prev_q  <= p_spawn;
                        life_q  <= 4'(MOLE_LIFE);
                        mask_q  <= 9'd1 << p_spawn;
                        state_q <= UP;
                    end
                    UP: if (hit || expire) begin
                        mask_q  <= '0;
                        gap_q   <= 4'(GAP_TICKS);
                        state_q <= GAP;
                    end else if (tick) begin
                        life_q <= life_q - 4'd1;
                    end
                    GAP: if (tick) begin
                        if (gap_q == 4'd1) state_q <= SPAWN;
                        gap_q <= gap_q - 4'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign mole_mask = mask_q;
    assign score     = score_q;
    assign miss_cnt  = miss_q;
    assign time_left = time_q;
    assign game_over = over_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: directed scenarios plus random play against a cycle-level game model.
module tb_mole_game_ctrl;
    localparam int TD = 4, GT = 10, ML = 2, GP = 1;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [3:0] hit_pos = 4'hF;
    logic [8:0] mole_mask;
    logic [7:0] score, miss_cnt;
    logic [6:0] time_left;
    logic       game_over, busy;
    int checks = 0, failures = 0;
    int m_lfsr, m_sub, m_tl, m_sc, m_ms, m_mole, m_prev, m_life, m_gap;
    string m_mode;
    int old, n, w, sc0, ms0;
    mole_game_ctrl #(.TICK_DIV(TD), .GAME_TICKS(GT), .MOLE_LIFE(ML), .GAP_TICKS(GP), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .hit_pos(hit_pos), .mole_mask(mole_mask),
        .score(score), .miss_cnt(miss_cnt), .time_left(time_left), .game_over(game_over), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask
    function automatic bit m_busy();
        return m_mode == "SPAWN" || m_mode == "UP" || m_mode == "GAP";
    endfunction
    task automatic model_step(input bit r, input bit s, input int hp);
        int l0, p;
        bit bz, tick, fin, hitc, wrongc;
        if (r) begin
            m_mode = "IDLE"; m_lfsr = 'hACE1; m_sub = 0; m_tl = 0; m_sc = 0; m_ms = 0;
            m_mole = -1; m_prev = 15; m_life = 0; m_gap = 0;
            return;
        end
        l0 = m_lfsr;
        m_lfsr = ((l0 << 1) & 'hFFFF) | (((l0 >> 15) ^ (l0 >> 13) ^ (l0 >> 12) ^ (l0 >> 10)) & 1);
        bz = m_busy();
        tick = bz && m_sub == TD - 1;
        m_sub = (bz && !tick) ? m_sub + 1 : 0;
        hitc = m_mode == "UP" && hp == m_mole;
        wrongc = m_mode == "UP" && hp < 9 && hp != m_mole;
        fin = tick && m_tl == 1;
        if (tick) m_tl--;
        if (hitc && m_sc < 255) m_sc++;
        if (wrongc && m_ms < 255) m_ms++;
        if (fin) begin
            m_mode = "OVER"; m_mole = -1;
        end else if (m_mode == "IDLE" || m_mode == "OVER") begin
            if (s) begin m_mode = "SPAWN"; m_sc = 0; m_ms = 0; m_tl = GT; m_prev = 15; end
        end else if (m_mode == "SPAWN") begin
            p = l0 % 16;
            if (p >= 9) p -= 9;
            if (p == m_prev) p = (p + 1) % 9;
            m_mole = p; m_prev = p; m_life = ML; m_mode = "UP";
        end else if (m_mode == "UP") begin
            if (hitc) begin
                m_mole = -1; m_gap = GP; m_mode = "GAP";
            end else if (tick) begin
                m_life--;
                if (m_life == 0) begin
                    if (m_ms < 255) m_ms++;
                    m_mole = -1; m_gap = GP; m_mode = "GAP";
                end
            end
        end else if (m_mode == "GAP" && tick) begin
            m_gap--;
            if (m_gap == 0) m_mode = "SPAWN";
        end
    endtask
    task automatic cyc(input bit r, input bit s, input logic [3:0] hp);
        rst = r; start = s; hit_pos = hp;
        @(posedge clk);
        model_step(r, s, int'(hp));
        #1;
        chk("mask", 32'(mole_mask), m_mole < 0 ? 32'd0 : 32'(1 << m_mole));
        chk("score", 32'(score), 32'(m_sc));
        chk("miss", 32'(miss_cnt), 32'(m_ms));
        chk("time", 32'(time_left), 32'(m_tl));
        chk("over", 32'(game_over), 32'(m_mode == "OVER"));
        chk("busy", 32'(busy), 32'(m_busy()));
        rst = 1'b0; start = 1'b0; hit_pos = 4'hF;
    endtask
    initial begin
        cyc(1, 0, 15); cyc(1, 0, 15);
        chk("rst_mask", 32'(mole_mask), 0); chk("rst_score", 32'(score), 0);
        chk("rst_miss", 32'(miss_cnt), 0); chk("rst_time", 32'(time_left), 0);
        chk("rst_over", 32'(game_over), 0); chk("rst_busy", 32'(busy), 0);
        cyc(0, 1, 15);
        chk("s1_busy", 32'(busy), 1); chk("s1_time", 32'(time_left), 10);
        cyc(0, 0, 15);
        chk("s1_onehot", 32'($countones(mole_mask)), 1);
        old = m_mole;
        cyc(0, 0, 4'(old));
        chk("s2_score", 32'(score), 1); chk("s2_mask", 32'(mole_mask), 0);
        n = 0;
        while (mole_mask == 0 && n < 20) begin cyc(0, 0, 15); n++; end
        chk("s2_respawn", 32'(n < 20), 1);
        chk("s2_samepos", 32'(mole_mask == 9'(1 << old)), 0);
        cyc(1, 0, 15); cyc(0, 1, 15); cyc(0, 0, 15);
        w = (m_mole + 1) % 9;
        cyc(0, 0, 4'(w));
        chk("s3_miss1", 32'(miss_cnt), 1);
        cyc(0, 0, 12);
        chk("s3_ign_miss", 32'(miss_cnt), 1); chk("s3_ign_score", 32'(score), 0);
        repeat (6) cyc(0, 0, 15);
        chk("s3_miss2", 32'(miss_cnt), 2); chk("s3_mask", 32'(mole_mask), 0);
        cyc(1, 0, 15); cyc(0, 1, 15);
        n = 0;
        while (!(m_mode == "UP" && m_sub == TD - 1 && m_life == 1) && n < 20) begin cyc(0, 0, 15); n++; end
        chk("s4_reach", 32'(n < 20), 1);
        sc0 = score; ms0 = miss_cnt;
        cyc(0, 0, 4'(m_mole));
        chk("s4_score", 32'(score), 32'(sc0 + 1)); chk("s4_miss", 32'(miss_cnt), 32'(ms0));
        cyc(1, 0, 15); cyc(0, 1, 15);
        repeat (40) cyc(0, 0, 15);
        chk("s5_time", 32'(time_left), 0); chk("s5_over", 32'(game_over), 1); chk("s5_mask", 32'(mole_mask), 0);
        cyc(0, 1, 15);
        chk("s5_rs_score", 32'(score), 0); chk("s5_rs_miss", 32'(miss_cnt), 0); chk("s5_rs_time", 32'(time_left), 10);
        cyc(1, 0, 15); cyc(0, 1, 15); cyc(0, 0, 15); cyc(0, 0, 15);
        cyc(1, 0, 15);
        chk("s6_mask", 32'(mole_mask), 0); chk("s6_score", 32'(score), 0); chk("s6_miss", 32'(miss_cnt), 0);
        chk("s6_time", 32'(time_left), 0); chk("s6_over", 32'(game_over), 0); chk("s6_busy", 32'(busy), 0);
        cyc(0, 1, 15);
        repeat (5) cyc(0, 0, 15);
        cyc(0, 1, 15);
        chk("s6_start_ign", 32'(time_left), 9); chk("s6_busy2", 32'(busy), 1);
        for (int i = 0; i < 3000; i++) begin
            bit r, s;
            logic [3:0] hp;
            r = $urandom_range(0, 499) == 0;
            s = $urandom_range(0, 29) == 0;
            hp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0 && m_mole >= 0) hp = 4'(m_mole);
            cyc(r, s, hp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
